// File: rtl/vtd_pkg.sv
// Shared types and defaults for the video timing detector.
// State encoding, default counter widths and the lock-frame ceiling.
package vtd_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    CHECK   = 2'd2,
    LOCK    = 2'd3
  } vtd_state_e;

  localparam int VTD_HW              = 12;
  localparam int VTD_VW              = 11;
  localparam int VTD_LOCK_FRAMES_MAX = 15;

endpackage

// File: rtl/vtd_edge_det.sv
// Two-stage input register with rise/fall detection.
// lvl is the second-stage (settled) level of the input.
module vtd_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise,
  output logic fall,
  output logic lvl
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;

  always_comb begin
    s1_d = d;
    s2_d = s1_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign rise = s1_q & ~s2_q;
  assign fall = ~s1_q & s2_q;
  assign lvl  = s2_q;

endmodule

// File: rtl/video_timing_detector.sv
// Measures line total, active width and active height of a sync/DE stream.
// Optional VTD_ERR_CNT_EN adds a saturating LOCK_LOSS_CNT output.
module video_timing_detector
  import vtd_pkg::*;
#(
  parameter int HW          = VTD_HW,
  parameter int VW          = VTD_VW,
  parameter int LOCK_FRAMES = 3
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          HSYNC_IN,
  input  logic          VSYNC_IN,
  input  logic          DE_IN,
  output logic [HW-1:0] H_TOTAL,
  output logic [HW-1:0] H_ACTIVE,
  output logic [VW-1:0] V_ACTIVE,
  output logic          LOCKED,
  output logic          SOF,
`ifdef VTD_ERR_CNT_EN
  output logic [7:0]    LOCK_LOSS_CNT,
`endif
  output logic          OVF
);

  localparam logic [HW-1:0] H_MAX = '1;
  localparam logic [VW-1:0] V_MAX = '1;
  localparam logic [4:0]    LF    = 5'(LOCK_FRAMES);

  logic hs_rise, hs_fall, hs_lvl;
  logic vs_rise, vs_fall, vs_lvl;
  logic de_rise, de_fall, de_lvl;
  logic unused_edges;

  vtd_edge_det u_hs (.clk(CLK), .rst(RST), .d(HSYNC_IN),
                     .rise(hs_rise), .fall(hs_fall), .lvl(hs_lvl));
  vtd_edge_det u_vs (.clk(CLK), .rst(RST), .d(VSYNC_IN),
                     .rise(vs_rise), .fall(vs_fall), .lvl(vs_lvl));
  vtd_edge_det u_de (.clk(CLK), .rst(RST), .d(DE_IN),
                     .rise(de_rise), .fall(de_fall), .lvl(de_lvl));

  assign unused_edges = ^{hs_fall, hs_lvl, vs_fall, vs_lvl, de_rise};

  logic [HW-1:0] cnt_h_q, cnt_h_d, line_total_q, line_total_d;
  logic [HW-1:0] ht_ref_q, ht_ref_d, cnt_de_q, cnt_de_d;
  logic [HW-1:0] de_ref_q, de_ref_d, de_last_q, de_last_d;
  logic [HW-1:0] h_total_q, h_total_d, h_active_q, h_active_d;
  logic [VW-1:0] v_q, v_d, v_active_q, v_active_d;
  logic          ht_cap_q, ht_cap_d, de_cap_q, de_cap_d;
  logic          mis_q, mis_d, ovf_q, ovf_d;
  logic          ovf_out_q, ovf_out_d, sof_q, sof_d;
  logic [3:0]    match_q, match_d;
  logic [4:0]    match_nx;
  logic [HW-1:0] run;
  logic          frame_ok;
  vtd_state_e    st_q, st_d;
`ifdef VTD_ERR_CNT_EN
  logic [7:0]    loss_q, loss_d;
`endif

  always_comb begin
    cnt_h_d      = cnt_h_q;
    line_total_d = line_total_q;
    ht_ref_d     = ht_ref_q;
    ht_cap_d     = ht_cap_q;
    cnt_de_d     = cnt_de_q;
    de_ref_d     = de_ref_q;
    de_cap_d     = de_cap_q;
    de_last_d    = de_last_q;
    v_d          = v_q;
    mis_d        = mis_q;
    ovf_d        = ovf_q;
    h_total_d    = h_total_q;
    h_active_d   = h_active_q;
    v_active_d   = v_active_q;
    ovf_out_d    = ovf_out_q;
    sof_d        = 1'b0;
    st_d         = st_q;
    match_d      = match_q;
    match_nx     = {1'b0, match_q} + 5'd1;
    frame_ok     = 1'b0;
    run          = (cnt_de_q == H_MAX) ? H_MAX : cnt_de_q + 1'b1;
`ifdef VTD_ERR_CNT_EN
    loss_d       = loss_q;
`endif

    if (hs_rise) begin
      line_total_d = cnt_h_q;
      cnt_h_d      = HW'(1);
      if (!ht_cap_q) begin
        ht_ref_d = cnt_h_q;
        ht_cap_d = 1'b1;
      end else if (cnt_h_q != ht_ref_q) begin
        mis_d = 1'b1;
      end
    end else if (cnt_h_q == H_MAX) begin
      ovf_d = 1'b1;
    end else begin
      cnt_h_d = cnt_h_q + 1'b1;
    end

    // the falling cycle is itself a DE-high cycle, hence run = cnt + 1
    if (de_fall) begin
      if (!de_cap_q) begin
        de_ref_d = run;
        de_cap_d = 1'b1;
      end else if (run != de_ref_q) begin
        mis_d = 1'b1;
      end
      de_last_d = run;
      cnt_de_d  = '0;
      if (v_q == V_MAX) ovf_d = 1'b1;
      else              v_d   = v_q + 1'b1;
    end else if (de_lvl) begin
      if (cnt_de_q == H_MAX) ovf_d    = 1'b1;
      else                   cnt_de_d = cnt_de_q + 1'b1;
    end

    // frame close uses the _d values so same-cycle line/run events count
    if (vs_rise) begin
      frame_ok   = !mis_d && !ovf_d && (v_d != '0) &&
                   (line_total_d == h_total_q) &&
                   (de_last_d == h_active_q) &&
                   (v_d == v_active_q);
      h_total_d  = line_total_d;
      h_active_d = de_last_d;
      v_active_d = v_d;
      ovf_out_d  = ovf_d;
      sof_d      = 1'b1;
      v_d        = '0;
      mis_d      = 1'b0;
      ovf_d      = 1'b0;
      ht_cap_d   = 1'b0;
      de_cap_d   = 1'b0;
      de_last_d  = '0;
      unique case (st_q)
        IDLE:    st_d = MEASURE;
        MEASURE: begin
          st_d    = CHECK;
          match_d = '0;
        end
        CHECK: begin
          if (frame_ok) begin
            match_d = match_nx[3:0];
            if (match_nx >= LF) st_d = LOCK;
          end else begin
            match_d = '0;
          end
        end
        LOCK: begin
          if (!frame_ok) begin
            st_d    = CHECK;
            match_d = '0;
`ifdef VTD_ERR_CNT_EN
            if (loss_q != 8'hFF) loss_d = loss_q + 8'd1;
`endif
          end
        end
        default: st_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_h_q      <= '0;
      line_total_q <= '0;
      ht_ref_q     <= '0;
      ht_cap_q     <= 1'b0;
      cnt_de_q     <= '0;
      de_ref_q     <= '0;
      de_cap_q     <= 1'b0;
      de_last_q    <= '0;
      v_q          <= '0;
      mis_q        <= 1'b0;
      ovf_q        <= 1'b0;
      h_total_q    <= '0;
      h_active_q   <= '0;
      v_active_q   <= '0;
      ovf_out_q    <= 1'b0;
      sof_q        <= 1'b0;
      st_q         <= IDLE;
      match_q      <= '0;
`ifdef VTD_ERR_CNT_EN
      loss_q       <= '0;
`endif
    end else begin
      cnt_h_q      <= cnt_h_d;
      line_total_q <= line_total_d;
      ht_ref_q     <= ht_ref_d;
      ht_cap_q     <= ht_cap_d;
      cnt_de_q     <= cnt_de_d;
      de_ref_q     <= de_ref_d;
      de_cap_q     <= de_cap_d;
      de_last_q    <= de_last_d;
      v_q          <= v_d;
      mis_q        <= mis_d;
      ovf_q        <= ovf_d;
      h_total_q    <= h_total_d;
      h_active_q   <= h_active_d;
      v_active_q   <= v_active_d;
      ovf_out_q    <= ovf_out_d;
      sof_q        <= sof_d;
      st_q         <= st_d;
      match_q      <= match_d;
`ifdef VTD_ERR_CNT_EN
      loss_q       <= loss_d;
`endif
    end
  end

  assign H_TOTAL  = h_total_q;
  assign H_ACTIVE = h_active_q;
  assign V_ACTIVE = v_active_q;
  assign LOCKED   = (st_q == LOCK);
  assign SOF      = sof_q;
  assign OVF      = ovf_out_q;
`ifdef VTD_ERR_CNT_EN
  assign LOCK_LOSS_CNT = loss_q;
`endif

endmodule

// File: tb/tb_video_timing_detector.sv
// Bench for video_timing_detector: table rows, corner sequences, random rows.
// Expected geometry and lock come from a frame-level model of the line list.
module tb_video_timing_detector;

  localparam int HW   = 12;
  localparam int VW   = 11;
  localparam int LF   = 3;
  localparam int HMAX = (1 << HW) - 1;

  logic          CLK = 1'b0;
  logic          RST;
  logic          HSYNC_IN, VSYNC_IN, DE_IN;
  logic [HW-1:0] H_TOTAL, H_ACTIVE;
  logic [VW-1:0] V_ACTIVE;
  logic          LOCKED, SOF, OVF;
`ifdef VTD_ERR_CNT_EN
  logic [7:0]    LOCK_LOSS_CNT;
`endif

  video_timing_detector #(.HW(HW), .VW(VW), .LOCK_FRAMES(LF)) dut (
    .CLK(CLK), .RST(RST),
    .HSYNC_IN(HSYNC_IN), .VSYNC_IN(VSYNC_IN), .DE_IN(DE_IN),
    .H_TOTAL(H_TOTAL), .H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE),
    .LOCKED(LOCKED), .SOF(SOF),
`ifdef VTD_ERR_CNT_EN
    .LOCK_LOSS_CNT(LOCK_LOSS_CNT),
`endif
    .OVF(OVF)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int cyc;
    int htot;
    int hact;
    int vact;
    bit ovf;
    bit locked;
    bit geom;
    int loss;
  } exp_t;

  typedef struct {
    int len;
    int de;
    int lines;
    int delines;
    int voff;
    int frames;
    int mod;
    int e_htot;
    int e_hact;
    int e_vact;
    bit e_ovf;
    bit e_locked;
  } row_t;

  exp_t exp_q[$];
  int   acc_len[$];
  int   acc_de[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   sof_idx  = 0;
  int   streak   = 0;
  int   m_htot   = 0;
  int   m_hact   = 0;
  int   m_vact   = 0;
  int   m_loss   = 0;
  bit   m_locked = 1'b0;
  row_t rows[6];

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d cyc=%0d", name, act, req, cyc);
    end
  endtask

  task automatic monitor();
    exp_t e;
    if (SOF) begin
      chk("sof_timing", (exp_q.size() > 0 && exp_q[0].cyc == cyc), 1);
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        e = exp_q.pop_front();
        chk("sof_locked", LOCKED, e.locked);
        if (e.geom) begin
          chk("sof_h_total", H_TOTAL, e.htot);
          chk("sof_h_active", H_ACTIVE, e.hact);
          chk("sof_v_active", V_ACTIVE, e.vact);
          chk("sof_ovf", OVF, e.ovf);
        end
`ifdef VTD_ERR_CNT_EN
        chk("sof_lock_loss", LOCK_LOSS_CNT, e.loss);
`endif
      end
    end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      chk("sof_missing", SOF, 1);
      void'(exp_q.pop_front());
    end
  endtask

  task automatic tick(input logic h, input logic v, input logic d);
    HSYNC_IN = h;
    VSYNC_IN = v;
    DE_IN    = d;
    @(posedge CLK);
    #1;
    cyc++;
    monitor();
  endtask

  // Frame-level expectation from the list of lines that closed in the frame.
  function automatic void model_boundary(input int stamp);
    exp_t e;
    int   n, htot, hact, vact, first_de;
    bit   mis, ovf, valid, lk;
    n = acc_len.size();
    htot = 0; hact = 0; vact = 0; first_de = 0; mis = 0; ovf = 0;
    for (int i = 0; i < n; i++) begin
      if (acc_len[i] > HMAX) ovf = 1;
      if (acc_len[i] != acc_len[0]) mis = 1;
      if (acc_de[i] > 0) begin
        if (first_de == 0) first_de = acc_de[i];
        else if (acc_de[i] != first_de) mis = 1;
        hact = acc_de[i];
        vact++;
      end
    end
    if (n > 0) htot = (acc_len[n-1] > HMAX) ? HMAX : acc_len[n-1];
    sof_idx++;
    valid = !mis && !ovf && vact != 0 &&
            htot == m_htot && hact == m_hact && vact == m_vact;
    if (sof_idx <= 2) streak = 0;
    else              streak = valid ? streak + 1 : 0;
    lk = (sof_idx >= 3) && (streak >= LF);
    if (m_locked && !lk && m_loss < 255) m_loss++;
    m_locked = lk;
    m_htot = htot; m_hact = hact; m_vact = vact;
    e.cyc = stamp; e.htot = htot; e.hact = hact; e.vact = vact;
    e.ovf = ovf; e.locked = lk; e.geom = (sof_idx >= 2); e.loss = m_loss;
    exp_q.push_back(e);
    acc_len.delete();
    acc_de.delete();
  endfunction

  function automatic void model_reset();
    exp_q.delete();
    acc_len.delete();
    acc_de.delete();
    sof_idx = 0; streak = 0; m_locked = 0; m_loss = 0;
    m_htot = 0; m_hact = 0; m_vact = 0;
  endfunction

  // vsm: 0 vsync low, 1 vsync rises at voff, 2 vsync high all line
  task automatic send_line(input int len, input int de, input int vsm, input int voff);
    if (vsm == 1) model_boundary(cyc + voff + 2);
    acc_len.push_back(len);
    acc_de.push_back(de);
    for (int c = 0; c < len; c++)
      tick(c < 2, vsm == 2 || (vsm == 1 && c >= voff), c >= 4 && c < 4 + de);
  endtask

  task automatic send_lines(input int len, input int de, input int lines,
                            input int delines, input int voff, input int mod,
                            input int from, input int upto);
    int d;
    for (int l = from; l < upto; l++) begin
      d = (l >= 1 && l <= delines) ? de : 0;
      if (mod == 1 && l == 5 && d > 0) d = d - 1;
      if (mod == 2) d = 0;
      send_line(len, d, (l == 0) ? 1 : ((l == 1) ? 2 : 0), voff);
    end
    if (mod == 3 && upto == lines) send_line(5002, 0, 0, 0);
  endtask

  task automatic send_frame(input int len, input int de, input int lines,
                            input int delines, input int voff, input int mod);
    send_lines(len, de, lines, delines, voff, mod, 0, lines);
  endtask

  initial begin
    rows[0] = '{20, 16, 15, 12, 0, 6, 0, 20,   16, 12, 1'b0, 1'b1};
    rows[1] = '{20, 16, 15, 12, 5, 3, 0, 20,   16, 12, 1'b0, 1'b1};
    rows[2] = '{20, 16, 15, 12, 0, 5, 1, 20,   16, 12, 1'b0, 1'b1};
    rows[3] = '{20, 16, 15, 12, 0, 2, 2, 20,   0,  0,  1'b0, 1'b0};
    rows[4] = '{20, 16, 15, 12, 0, 2, 3, HMAX, 16, 12, 1'b1, 1'b0};
    rows[5] = '{20, 16, 15, 12, 0, 6, 0, 20,   16, 12, 1'b0, 1'b1};

    RST = 1'b1;
    HSYNC_IN = 0; VSYNC_IN = 0; DE_IN = 0;
    repeat (3) tick(0, 0, 0);
    chk("rst_h_total", H_TOTAL, 0);
    chk("rst_h_active", H_ACTIVE, 0);
    chk("rst_v_active", V_ACTIVE, 0);
    chk("rst_locked", LOCKED, 0);
    chk("rst_sof", SOF, 0);
    chk("rst_ovf", OVF, 0);
    RST = 1'b0;
    model_reset();

    for (int r = 0; r < 6; r++) begin
      for (int f = 0; f < rows[r].frames; f++)
        send_frame(rows[r].len, rows[r].de, rows[r].lines, rows[r].delines,
                   rows[r].voff, (f == 0) ? rows[r].mod : 0);
      chk($sformatf("row%0d_h_total", r), H_TOTAL, rows[r].e_htot);
      chk($sformatf("row%0d_h_active", r), H_ACTIVE, rows[r].e_hact);
      chk($sformatf("row%0d_v_active", r), V_ACTIVE, rows[r].e_vact);
      chk($sformatf("row%0d_ovf", r), OVF, rows[r].e_ovf);
      chk($sformatf("row%0d_locked", r), LOCKED, rows[r].e_locked);
    end

    // reset in the middle of a locked frame, then reacquire
    chk("pre_reset_locked", LOCKED, 1);
    send_lines(20, 16, 15, 12, 0, 0, 0, 7);
    RST = 1'b1;
    #1;
    chk("midrst_h_total", H_TOTAL, 0);
    chk("midrst_h_active", H_ACTIVE, 0);
    chk("midrst_v_active", V_ACTIVE, 0);
    chk("midrst_locked", LOCKED, 0);
    chk("midrst_ovf", OVF, 0);
`ifdef VTD_ERR_CNT_EN
    chk("midrst_lock_loss", LOCK_LOSS_CNT, 0);
`endif
    model_reset();
    repeat (3) tick(0, 0, 0);
    RST = 1'b0;
    send_lines(20, 16, 15, 12, 0, 0, 7, 15);
    for (int f = 0; f < 4; f++) begin
      send_frame(20, 16, 15, 12, 0, 0);
      chk($sformatf("relock_early_%0d", f), LOCKED, 0);
    end
    send_frame(20, 16, 15, 12, 0, 0);
    chk("relock_after_5_sof", LOCKED, 1);

    for (int r = 0; r < 6; r++) begin
      int len, de, lines, delines, voff, frames, mod;
      len     = 12 + int'($urandom % 16);
      de      = 1 + int'($urandom % (len - 8));
      lines   = 4 + int'($urandom % 6);
      delines = 1 + int'($urandom % (lines - 1));
      voff    = int'($urandom % 4);
      frames  = 2 + int'($urandom % 3);
      mod     = int'($urandom % 3);
      for (int f = 0; f < frames; f++)
        send_frame(len, de, lines, delines, voff, (f == 0) ? mod : 0);
    end

    repeat (4) tick(0, 0, 0);
    chk("sof_queue_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
